// File: rtl/hex_digit_scanner.sv
// Purpose: time-multiplexed scanner that walks a multi-digit hex value one nibble
//   at a time, driving the seven-segment decoder nibble and the matching anode.
// Latency: outputs are registered, one cycle behind the internal digit index and
//   display value. Backpressure: none; the scan free-runs, load is a fire-and-forget strobe.
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   value_in, load - value to show (digit 0 = bits [3:0]) and its capture strobe
//   blank_lz       - blank leading zero digits (digit 0 always lit)
//   nibble_o       - nibble of the digit currently scanned, to the decoder
//   an_o           - anode enables, polarity set by ACTIVE_LOW_AN
//   digit_idx_o    - index of the digit currently scanned
//   frame_o        - one-cycle pulse after the last digit of each scan finishes
module hex_digit_scanner #(
  parameter int NUM_DIGITS    = 8,
  parameter int REFRESH_DIV   = 100000,
  parameter bit ACTIVE_LOW_AN = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       value_in,
  input  logic                          load,
  input  logic                          blank_lz,
  output logic [3:0]                    nibble_o,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
  output logic                          frame_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] disp;
  logic                    pending;

  logic                    tick;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [NUM_DIGITS-1:0]   an_act;
  logic [3:0]              cur_nib;

  assign tick      = (cnt == CNT_LAST);
  assign frame_end = tick && (idx == IDX_LAST);

  // Refresh counter and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Value path: loads land in shadow and are promoted only at the frame
  // boundary, so a single scan never shows a mix of two values. A load on the
  // boundary cycle itself goes straight to disp.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        disp <= value_in;
      end else if (pending) begin
        disp <= shadow;
      end
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= value_in;
      pending <= 1'b1;
    end
  end

  // Leading-zero blanking: walk from the most significant digit down,
  // tracking whether every nibble at or above position k is zero.
  always_comb begin : blank_calc
    logic zero_run;
    zero_run  = 1'b1;
    blank_vec = '0;
    an_act    = '0;
    cur_nib   = 4'h0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run && (disp[4*k +: 4] == 4'h0);
      blank_vec[k] = blank_lz && zero_run && (k != 0);
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        an_act[k] = !blank_vec[k];
        cur_nib   = disp[4*k +: 4];
      end
    end
  end

  // Registered outputs; XOR with the polarity mask makes "inactive" all ones
  // for active-low anodes and all zeros for active-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      nibble_o    <= 4'h0;
      digit_idx_o <= '0;
      frame_o     <= 1'b0;
      an_o        <= {NUM_DIGITS{ACTIVE_LOW_AN}};
    end else begin
      nibble_o    <= cur_nib;
      digit_idx_o <= idx;
      frame_o     <= frame_end;
      an_o        <= an_act ^ {NUM_DIGITS{ACTIVE_LOW_AN}};
    end
  end

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Bench for hex_digit_scanner with NUM_DIGITS=4, REFRESH_DIV=4, active-low anodes.
// A cycle-count model derives digit position from elapsed time since reset and
// tracks the displayed value as "last load seen before each frame end".
module tb_hex_digit_scanner;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int FR = N * R;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        blank_lz;
  logic [15:0] value_in;
  logic [3:0]  nibble_o;
  logic [3:0]  an_o;
  logic [1:0]  digit_idx_o;
  logic        frame_o;

  int checks   = 0;
  int failures = 0;

  // Model state
  bit          m_ok = 1'b0;
  int          mt   = 0;
  logic [15:0] mdisp;
  logic [15:0] mpend_val;
  bit          mpend;
  logic [3:0]  e_nib;
  logic [3:0]  e_an;
  logic [1:0]  e_idx;
  logic        e_frame;

  always #5 clk = ~clk;

  hex_digit_scanner #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .ACTIVE_LOW_AN(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .nibble_o   (nibble_o),
    .an_o       (an_o),
    .digit_idx_o(digit_idx_o),
    .frame_o    (frame_o)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance until the next edge to be processed sits at frame phase p.
  task automatic wait_phase(input int p);
    int k;
    k = 0;
    while ((mt % FR) != p && k < 3 * FR) begin
      @(negedge clk);
      k++;
    end
    if ((mt % FR) != p) begin
      checks++;
      failures++;
      $display("FAIL wait_phase actual=%0d expected=%0d", mt % FR, p);
    end
  endtask

  // Called with the first digit of a frame on the outputs; checks all digits.
  task automatic check_frame(input logic [15:0] nibs, input logic [15:0] ans);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("frame_nib%0d", k), {12'h0, nibble_o}, {12'h0, nibs[4*k +: 4]});
      chk($sformatf("frame_an%0d", k), {12'h0, an_o}, {12'h0, ans[4*k +: 4]});
      if (k < N - 1) step(R);
    end
  endtask

  // Load on the frame-end cycle, then stop on digit 0 of the new frame.
  task automatic load_at_end(input logic [15:0] v);
    wait_phase(FR - 1);
    load     = 1'b1;
    value_in = v;
    step(1);
    load     = 1'b0;
    value_in = 16'($urandom);
    step(1);
  endtask

  // Behavioural model: position in the scan comes from elapsed cycles.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ok    = 1'b1;
        mt      = 0;
        mdisp   = 16'h0;
        mpend   = 1'b0;
        e_nib   = 4'h0;
        e_an    = 4'hF;
        e_idx   = 2'd0;
        e_frame = 1'b0;
      end else if (m_ok) begin
        int          d;
        bit          fe;
        logic [15:0] upper;
        d       = (mt / R) % N;
        fe      = (mt % FR) == FR - 1;
        upper   = mdisp >> (4 * d);
        e_idx   = d[1:0];
        e_nib   = upper[3:0];
        e_frame = fe;
        e_an    = (blank_lz && d != 0 && upper == 16'h0) ? 4'hF : ~(4'b0001 << d);
        if (fe) begin
          if (load) mdisp = value_in;
          else if (mpend) mdisp = mpend_val;
          mpend = 1'b0;
        end else if (load) begin
          mpend_val = value_in;
          mpend     = 1'b1;
        end
        mt++;
      end
    end
  end

  // Every-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        chk("nibble_o", {12'h0, nibble_o}, {12'h0, e_nib});
        chk("an_o", {12'h0, an_o}, {12'h0, e_an});
        chk("digit_idx_o", {14'h0, digit_idx_o}, {14'h0, e_idx});
        chk("frame_o", {15'h0, frame_o}, {15'h0, e_frame});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] masks [5];
    masks[0] = 16'hFFFF; masks[1] = 16'h0FFF; masks[2] = 16'h00FF;
    masks[3] = 16'h000F; masks[4] = 16'h0000;

    rst = 1'b1; load = 1'b0; blank_lz = 1'b0; value_in = 16'h0;
    step(3);
    chk("rst_an", {12'h0, an_o}, 16'h000F);
    chk("rst_nib", {12'h0, nibble_o}, 16'h0);
    chk("rst_idx", {14'h0, digit_idx_o}, 16'h0);
    chk("rst_frame", {15'h0, frame_o}, 16'h0);
    rst = 1'b0;

    // Free-running scan after reset, no load.
    step(1);
    chk("rel_an0", {12'h0, an_o}, 16'h000E);
    chk("rel_nib0", {12'h0, nibble_o}, 16'h0);
    step(4);
    chk("rel_an1", {12'h0, an_o}, 16'h000D);
    step(4);
    chk("rel_an2", {12'h0, an_o}, 16'h000B);
    step(7);
    chk("frame_pulse1", {15'h0, frame_o}, 16'h1);
    chk("rel_an3", {12'h0, an_o}, 16'h0007);
    step(1);
    chk("frame_low", {15'h0, frame_o}, 16'h0);
    step(15);
    chk("frame_pulse2", {15'h0, frame_o}, 16'h1);

    // Mid-frame load waits for the frame boundary.
    wait_phase(5);
    load = 1'b1; value_in = 16'hA5C3;
    step(1);
    load = 1'b0; value_in = 16'h0;
    wait_phase(FR - 1);
    chk("held_nib", {12'h0, nibble_o}, 16'h0);
    wait_phase(1);
    check_frame(16'hA5C3, 16'h7BDE);

    // Two loads in one frame: last wins.
    wait_phase(3);
    load = 1'b1; value_in = 16'h1111;
    step(1);
    load = 1'b0;
    wait_phase(9);
    load = 1'b1; value_in = 16'h2222;
    step(1);
    load = 1'b0;
    wait_phase(1);
    check_frame(16'h2222, 16'h7BDE);

    // Load coincident with frame end bypasses shadow.
    load_at_end(16'h0BEE);
    check_frame(16'h0BEE, 16'h7BDE);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    load_at_end(16'h00F0);
    check_frame(16'h00F0, 16'hFFDE);
    load_at_end(16'h0000);
    check_frame(16'h0000, 16'hFFFE);
    load_at_end(16'h1000);
    check_frame(16'h1000, 16'h7BDE);
    blank_lz = 1'b0;

    // Reset mid-digit with idx=2 and a load pending.
    wait_phase(8);
    load = 1'b1; value_in = 16'h7777;
    step(1);
    load = 1'b0;
    step(1);
    rst = 1'b1; load = 1'b1; value_in = 16'h5555;
    step(1);
    rst = 1'b0; load = 1'b0;
    chk("mid_rst_an", {12'h0, an_o}, 16'h000F);
    chk("mid_rst_nib", {12'h0, nibble_o}, 16'h0);
    step(1);
    chk("post_rst_an", {12'h0, an_o}, 16'h000E);
    chk("post_rst_nib", {12'h0, nibble_o}, 16'h0);
    wait_phase(FR - 1);
    step(2);
    check_frame(16'h0000, 16'h7BDE);

    // Randomized traffic, checked every cycle by the model.
    repeat (2000) begin
      rst      = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 7) == 0);
      value_in = 16'($urandom) & masks[$urandom_range(0, 4)];
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      step(1);
    end
    rst = 1'b0; load = 1'b0;
    step(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
